// File: rtl/soml_encoder_tx.sv
// Space-time-block (SOML) transmit encoder: maps a 12-bit frame word to two PAM
// symbols and streams the four entries of the rotated/permuted codeword.
module soml_encoder_tx #(
   parameter int N = 32,
   parameter int Q = 22
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bits_in_valid,
   input  logic [11:0]  bits_in,
   output logic         bits_in_ready,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [N-1:0] tx_r,
   output logic [N-1:0] tx_i,
   output logic         tx_slot,
   output logic         tx_ant,
   output logic         tx_last,
   output logic [4:0]   S_index,
   output logic [7:0]   frames_sent
);

   // state | meaning
   // IDLE  | ready for a frame word
   // MAP   | word registered; PAM levels and beat 0 being prepared
   // SEND  | streaming beats 0..3 under tx_valid/tx_ready
   typedef enum logic [1:0] {IDLE, MAP, SEND} state_t;

   state_t       state_q, state_d;
   logic [11:0]  word_q, word_d;
   logic [N-1:0] s1r_q, s1r_d, s1i_q, s1i_d, s2r_q, s2r_d, s2i_q, s2i_d;
   logic [1:0]   beat_q, beat_d;
   logic         tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
   logic         tx_slot_q, tx_slot_d, tx_ant_q, tx_ant_d;
   logic [N-1:0] tx_r_q, tx_r_d, tx_i_q, tx_i_d;
   logic [4:0]   s_index_q, s_index_d;
   logic [7:0]   frames_q, frames_d;

   logic [N-1:0] map_s1r, map_s1i, map_s2r, map_s2i;
   logic [1:0]   beat_nx;

   function automatic logic [N-1:0] pam(input logic [1:0] m);
      logic [N-1:0] one, three, lvl;
      one   = {{(N-1){1'b0}}, 1'b1} << Q;
      three = one + (one << 1);
      case (m)
         2'b00:   lvl = -three;
         2'b01:   lvl = -one;
         2'b10:   lvl = one;
         default: lvl = three;
      endcase
      return lvl;
   endfunction

   // Y[t][a] = j^k * X[t^q1][a^q0]; result packed as {real, imag}
   function automatic logic [2*N-1:0] entry(input logic [3:0] q, input logic t, input logic a,
                                            input logic [N-1:0] s1r, input logic [N-1:0] s1i,
                                            input logic [N-1:0] s2r, input logic [N-1:0] s2i);
      logic [N-1:0] xr, xi, yr, yi;
      case ({t ^ q[1], a ^ q[0]})
         2'b00:   begin xr = s1r;  xi = s1i;  end
         2'b01:   begin xr = s2r;  xi = s2i;  end
         2'b10:   begin xr = -s2r; xi = s2i;  end
         default: begin xr = s1r;  xi = -s1i; end
      endcase
      case (q[3:2])
         2'd0:    begin yr = xr;  yi = xi;  end
         2'd1:    begin yr = -xi; yi = xr;  end
         2'd2:    begin yr = -xr; yi = -xi; end
         default: begin yr = xi;  yi = -xr; end
      endcase
      return {yr, yi};
   endfunction

   assign map_s1r = pam(word_q[7:6]);
   assign map_s1i = pam(word_q[5:4]);
   assign map_s2r = pam(word_q[3:2]);
   assign map_s2i = pam(word_q[1:0]);
   assign beat_nx = beat_q + 2'd1;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      s1r_d      = s1r_q;
      s1i_d      = s1i_q;
      s2r_d      = s2r_q;
      s2i_d      = s2i_q;
      beat_d     = beat_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      tx_slot_d  = tx_slot_q;
      tx_ant_d   = tx_ant_q;
      tx_r_d     = tx_r_q;
      tx_i_d     = tx_i_q;
      s_index_d  = s_index_q;
      frames_d   = frames_q;
      case (state_q)
         IDLE: begin
            if (bits_in_valid) begin
               word_d    = bits_in;
               s_index_d = {1'b0, bits_in[11:8]};
               state_d   = MAP;
            end
         end
         MAP: begin
            s1r_d      = map_s1r;
            s1i_d      = map_s1i;
            s2r_d      = map_s2r;
            s2i_d      = map_s2i;
            {tx_r_d, tx_i_d} = entry(word_q[11:8], 1'b0, 1'b0, map_s1r, map_s1i, map_s2r, map_s2i);
            beat_d     = 2'd0;
            tx_slot_d  = 1'b0;
            tx_ant_d   = 1'b0;
            tx_last_d  = 1'b0;
            tx_valid_d = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            if (tx_ready) begin
               if (beat_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  frames_d   = frames_q + 8'd1;
                  state_d    = IDLE;
               end else begin
                  beat_d    = beat_nx;
                  {tx_r_d, tx_i_d} = entry(word_q[11:8], beat_nx[1], beat_nx[0],
                                           s1r_q, s1i_q, s2r_q, s2i_q);
                  tx_slot_d = beat_nx[1];
                  tx_ant_d  = beat_nx[0];
                  tx_last_d = (beat_nx == 2'd3);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         s1r_q      <= '0;
         s1i_q      <= '0;
         s2r_q      <= '0;
         s2i_q      <= '0;
         beat_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         tx_slot_q  <= 1'b0;
         tx_ant_q   <= 1'b0;
         tx_r_q     <= '0;
         tx_i_q     <= '0;
         s_index_q  <= '0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         s1r_q      <= s1r_d;
         s1i_q      <= s1i_d;
         s2r_q      <= s2r_d;
         s2i_q      <= s2i_d;
         beat_q     <= beat_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         tx_slot_q  <= tx_slot_d;
         tx_ant_q   <= tx_ant_d;
         tx_r_q     <= tx_r_d;
         tx_i_q     <= tx_i_d;
         s_index_q  <= s_index_d;
         frames_q   <= frames_d;
      end
   end

   assign bits_in_ready = (state_q == IDLE);
   assign tx_valid      = tx_valid_q;
   assign tx_last       = tx_last_q;
   assign tx_slot       = tx_slot_q;
   assign tx_ant        = tx_ant_q;
   assign tx_r          = tx_r_q;
   assign tx_i          = tx_i_q;
   assign S_index       = s_index_q;
   assign frames_sent   = frames_q;

endmodule

// File: tb/tb_soml_encoder_tx.sv
// Bench for soml_encoder_tx: directed and random frames checked against a
// complex-arithmetic model of the rotated/permuted codeword.
module tb_soml_encoder_tx;
   localparam int N = 32;
   localparam int Q = 22;

   logic         clk = 1'b0;
   logic         rst;
   logic         bits_in_valid;
   logic [11:0]  bits_in;
   logic         bits_in_ready;
   logic         tx_valid;
   logic         tx_ready;
   logic [N-1:0] tx_r, tx_i;
   logic         tx_slot, tx_ant, tx_last;
   logic [4:0]   S_index;
   logic [7:0]   frames_sent;

   int checks = 0;
   int errors = 0;
   int frames_model = 0;
   logic [N-1:0] obs_r [4];
   logic [N-1:0] obs_i [4];

   soml_encoder_tx #(.N(N), .Q(Q)) dut (
      .clk(clk), .rst(rst),
      .bits_in_valid(bits_in_valid), .bits_in(bits_in), .bits_in_ready(bits_in_ready),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_r(tx_r), .tx_i(tx_i), .tx_slot(tx_slot), .tx_ant(tx_ant), .tx_last(tx_last),
      .S_index(S_index), .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: symbols as integer complex numbers, scaled to Q format at the end.
   task automatic model(input logic [11:0] w, input int b, output logic [N-1:0] er, output logic [N-1:0] ei);
      int xr [2][2];
      int xi [2][2];
      int lv [4];
      int t, a, k, r, i, tmp;
      for (int n = 0; n < 4; n++) lv[n] = 2 * int'((w >> (6 - 2*n)) & 12'h3) - 3;
      xr[0][0] = lv[0];  xi[0][0] = lv[1];
      xr[0][1] = lv[2];  xi[0][1] = lv[3];
      xr[1][0] = -lv[2]; xi[1][0] = lv[3];
      xr[1][1] = lv[0];  xi[1][1] = -lv[1];
      t = b / 2;
      a = b % 2;
      k = int'(w >> 10);
      r = xr[t ^ int'(w[9])][a ^ int'(w[8])];
      i = xi[t ^ int'(w[9])][a ^ int'(w[8])];
      for (int n = 0; n < k; n++) begin
         tmp = r;
         r = -i;
         i = tmp;
      end
      er = N'(r * (1 << Q));
      ei = N'(i * (1 << Q));
   endtask

   // mode 0: tx_ready high; 1: pattern 1,0,0,1,0,1; 2: random ready plus junk words while busy
   task automatic send_frame(input logic [11:0] w, input int mode);
      int b, cyc;
      logic rdy;
      logic [N-1:0] er, ei;
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      check("ready_idle", 64'(bits_in_ready), 64'd1);
      bits_in_valid = 1'b1;
      bits_in       = w;
      @(negedge clk);
      bits_in_valid = (mode == 2);
      bits_in       = w ^ 12'hFFF;
      check("ready_map", 64'(bits_in_ready), 64'd0);
      check("valid_map", 64'(tx_valid), 64'd0);
      check("s_index", 64'(S_index), 64'({1'b0, w[11:8]}));
      @(negedge clk);
      b = 0;
      cyc = 0;
      while (b < 4 && cyc < 40) begin
         model(w, b, er, ei);
         check("tx_valid", 64'(tx_valid), 64'd1);
         check("tx_r", 64'(tx_r), 64'(er));
         check("tx_i", 64'(tx_i), 64'(ei));
         check("tx_slot", 64'(tx_slot), 64'(b / 2));
         check("tx_ant", 64'(tx_ant), 64'(b % 2));
         check("tx_last", 64'(tx_last), 64'(b == 3));
         check("ready_send", 64'(bits_in_ready), 64'd0);
         obs_r[b] = tx_r;
         obs_i[b] = tx_i;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 6];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tx_ready = rdy;
         if (rdy) begin
            if (b == 3) bits_in_valid = 1'b0;
            b++;
         end else if (mode == 2) begin
            bits_in_valid = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
      end
      bits_in_valid = 1'b0;
      check("frame_done", 64'(b), 64'd4);
      frames_model = (frames_model + 1) % 256;
      check("valid_end", 64'(tx_valid), 64'd0);
      check("frames_sent", 64'(frames_sent), 64'(frames_model));
      check("s_index_hold", 64'(S_index), 64'({1'b0, w[11:8]}));
      check("ready_end", 64'(bits_in_ready), 64'd1);
   endtask

   initial begin
      int acc;
      logic [11:0] w;
      rst = 1'b1;
      bits_in_valid = 1'b1;
      bits_in = 12'h5E4;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_s_index", 64'(S_index), 64'd0);
      rst = 1'b0;
      bits_in_valid = 1'b0;
      check("rst_tx_r", 64'(tx_r), 64'd0);
      check("rst_tx_i", 64'(tx_i), 64'd0);
      check("rst_slot_ant", 64'({tx_slot, tx_ant}), 64'd0);
      check("rst_last", 64'(tx_last), 64'd0);
      check("rst_frames", 64'(frames_sent), 64'd0);
      @(negedge clk);
      check("post_rst_ready", 64'(bits_in_ready), 64'd1);
      check("post_rst_valid", 64'(tx_valid), 64'd0);
      check("post_rst_s_index", 64'(S_index), 64'd0);

      send_frame(12'h000, 0);
      check("k0_b0_r", 64'(obs_r[0]), 64'h0000_0000_FF40_0000);
      check("k0_b0_i", 64'(obs_i[0]), 64'h0000_0000_FF40_0000);
      check("k0_b2_r", 64'(obs_r[2]), 64'h0000_0000_00C0_0000);
      check("k0_b3_i", 64'(obs_i[3]), 64'h0000_0000_00C0_0000);
      check("k0_frames", 64'(frames_sent), 64'd1);

      send_frame(12'h5E4, 0);
      check("k5_b0", 64'({obs_r[0], obs_i[0]}), {32'h00C0_0000, 32'hFFC0_0000});
      check("k5_b1", 64'({obs_r[1], obs_i[1]}), {32'hFFC0_0000, 32'h00C0_0000});
      check("k5_b2", 64'({obs_r[2], obs_i[2]}), {32'h0040_0000, 32'h00C0_0000});
      check("k5_b3", 64'({obs_r[3], obs_i[3]}), {32'h00C0_0000, 32'h0040_0000});
      check("k5_s_index", 64'(S_index), 64'd5);

      for (int n = 0; n < 4; n++) send_frame(12'($urandom), 1);
      for (int n = 0; n < 30; n++) send_frame(12'($urandom), 2);

      // Continuous offer: one accept every 6 cycles, 256 frames wrap the counter.
      w = 12'($urandom);
      bits_in = w;
      bits_in_valid = 1'b1;
      tx_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 1536; i++) begin
         check("cont_ready", 64'(bits_in_ready), 64'(i % 6 == 0));
         if (bits_in_ready) acc++;
         @(negedge clk);
      end
      bits_in_valid = 1'b0;
      check("cont_accepts", 64'(acc), 64'd256);
      check("cont_frames_wrap", 64'(frames_sent), 64'(frames_model));
      check("cont_s_index", 64'(S_index), 64'({1'b0, w[11:8]}));

      // Reset while beat 2 is on the bus.
      bits_in = 12'hA5C;
      bits_in_valid = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      bits_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_at_beat2", 64'({tx_valid, tx_slot, tx_ant}), 64'b110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      frames_model = 0;
      check("abort_valid", 64'(tx_valid), 64'd0);
      check("abort_frames", 64'(frames_sent), 64'd0);
      check("abort_tx_r", 64'(tx_r), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_beats", 64'(tx_valid), 64'd0);
      end
      send_frame(12'h3C9, 0);
      check("after_abort_frames", 64'(frames_sent), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
